// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor built from two half subtractors: d = a - b - c.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic bo
);

    logic d1;
    logic b1;
    logic b2;

    // First stage subtracts b from a, second stage subtracts the incoming borrow.
    half_sub u_hs0 (
        .a  (a),
        .b  (b),
        .d  (d1),
        .bo (b1)
    );

    half_sub u_hs1 (
        .a  (d1),
        .b  (c),
        .d  (d),
        .bo (b2)
    );

    // The two stages can never both borrow, so an OR merges them.
    assign bo = b1 | b2;

endmodule

// File: rtl/half_sub.sv
// One-bit half subtractor: d = a - b, bo set when b exceeds a.
module half_sub (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);

    assign d  = a ^ b;
    assign bo = ~a & b;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one shared full-subtract cell walks the
// operands LSB first, producing diff = a - b - bin with valid/ready on both sides.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int               CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             brw;
    logic             cell_d;
    logic             cell_bo;

    full_sub_cell u_cell (
        .a  (sa[0]),
        .b  (sb[0]),
        .c  (brw),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // State register, bit counter, operand/result shift registers and borrow FF.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            sa    <= '0;
            sb    <= '0;
            sd    <= '0;
            brw   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa    <= a_in;
                        sb    <= b_in;
                        brw   <= bin;
                        count <= '0;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
                    sd    <= {cell_d, sd[WIDTH-1:1]};
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    brw   <= cell_bo;
                    count <= count + 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // The edge that consumes bit WIDTH-1 is the last one in RUN.
                if (count == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Result outputs read as zero whenever no result is being offered.
    assign diff = out_valid ? sd : '0;
    assign bout = out_valid & brw;
    assign zero = out_valid & (sd == '0);

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and randomised checks of the bit-serial subtractor at WIDTH=8.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic       bin;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       in_ready;
    logic       out_valid;
    logic       bout;
    logic       zero;
    logic [7:0] diff;

    int total = 0;
    int bad   = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Present operands, wait for acceptance, return at the negedge after the accept edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c, output int ok);
        int n;
        @(negedge clk);
        a_in = a; b_in = b; bin = c; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = int'(in_ready);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count negedges until out_valid, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_in = 8'h00; b_in = 8'h00; bin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if ({diff, bout, zero} !== 10'h000) begin bad++; $display("FAIL reset_outputs diff=%h bout=%b zero=%b want 00/0/0", diff, bout, zero); end
        rst = 1'b0;
    endtask

    task automatic test_basic(input string name, input logic [7:0] a, input logic [7:0] b, input logic c,
                              input logic [7:0] ed, input logic eb, input logic ez);
        int ok;
        int lat;
        start_op(a, b, c, ok);
        total++; if (ok !== 1) begin bad++; $display("FAIL %s_accept in_ready never high", name); end
        wait_done(lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL %s_latency got=%0d want=8", name, lat); end
        total++; if (diff !== ed) begin bad++; $display("FAIL %s_diff got=%h want=%h", name, diff, ed); end
        total++; if (bout !== eb) begin bad++; $display("FAIL %s_bout got=%b want=%b", name, bout, eb); end
        total++; if (zero !== ez) begin bad++; $display("FAIL %s_zero got=%b want=%b", name, zero, ez); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL %s_release in_ready=%b out_valid=%b want 1/0", name, in_ready, out_valid); end
    endtask

    task automatic test_back_pressure();
        int ok;
        int lat;
        start_op(8'h05, 8'h04, 1'b0, ok);
        wait_done(lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL bp_latency got=%0d want=8", lat); end
        // A new request while DONE is held must be ignored.
        a_in = 8'hFF; b_in = 8'h00; bin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({out_valid, in_ready, diff} !== {1'b1, 1'b0, 8'h01}) begin
                bad++; $display("FAIL bp_hold cycle=%0d out_valid=%b in_ready=%b diff=%h want 1/0/01", i, out_valid, in_ready, diff);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_at_hs got=%b want=0", in_ready); end
        @(negedge clk);
        out_ready = 1'b0;
        total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL bp_after_hs in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_reset_mid_run();
        int ok;
        start_op(8'h05, 8'h04, 1'b0, ok);
        repeat (3) @(negedge clk);
        total++; if ({in_ready, out_valid} !== 2'b00) begin bad++; $display("FAIL mid_run_state in_ready=%b out_valid=%b want 0/0", in_ready, out_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({in_ready, out_valid, diff} !== {1'b1, 1'b0, 8'h00}) begin
            bad++; $display("FAIL mid_rst in_ready=%b out_valid=%b diff=%h want 1/0/00", in_ready, out_valid, diff);
        end
        test_basic("post_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [8:0] expq[$];
        logic [8:0] ev;
        int sent = 0;
        int recv = 0;
        int ccyc = 0;
        int pcyc = 0;
        logic acc = 1'b0;
        fork
            begin
                while (sent < 200 && pcyc < 20000) begin
                    @(negedge clk);
                    pcyc++;
                    if (acc) begin in_valid = 1'b0; acc = 1'b0; end
                    if (!in_valid && $urandom_range(0, 2) == 0) begin
                        a_in = 8'($urandom); b_in = 8'($urandom); bin = 1'($urandom_range(0, 1));
                        in_valid = 1'b1;
                    end
                    if (in_valid && in_ready) begin
                        expq.push_back({1'b0, a_in} - {1'b0, b_in} - 9'(bin));
                        sent++;
                        acc = 1'b1;
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                while (recv < 200 && ccyc < 20000) begin
                    @(negedge clk);
                    ccyc++;
                    out_ready = ($urandom_range(0, 2) != 0);
                    if (out_valid && out_ready) begin
                        total++;
                        if (expq.size() == 0) begin
                            bad++; $display("FAIL rand_extra result=%b_%h want no result pending", bout, diff);
                        end else begin
                            ev = expq.pop_front();
                            if ({bout, diff} !== ev) begin
                                bad++; $display("FAIL rand_op%0d got=%b_%h want=%b_%h", recv, bout, diff, ev[8], ev[7:0]);
                            end
                        end
                        recv++;
                    end
                end
                @(negedge clk);
                out_ready = 1'b0;
            end
        join
        total++;
        if (sent !== 200 || recv !== 200 || expq.size() !== 0) begin
            bad++; $display("FAIL rand_count sent=%0d recv=%0d pending=%0d want 200/200/0", sent, recv, expq.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic("sub_05_04", 8'h05, 8'h04, 1'b0, 8'h01, 1'b0, 1'b0);
        test_basic("sub_03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        test_basic("sub_00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        test_basic("sub_7a_7a", 8'h7A, 8'h7A, 1'b0, 8'h00, 1'b0, 1'b1);
        test_basic("sub_80_01_b", 8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 1'b0);
        test_back_pressure();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
